cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling controller that sits directly upstream of the cache data/tag arrays. When the cache reports a miss, it fetches the missing 16-byte block (8 words) from the multi-cycle main memory. It streams each returned word into the cache by driving the data-array write strobe, word index and write data, then writes the tag on the final word. While a fill is in progress it holds the pipeline stalled via `fsm_busy`.

## Interface
- `ADDR_WIDTH`, 16, byte address width.
- `DATA_WIDTH`, 16, word width; block is fixed at 8 words.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `miss_detected`  in  1  cache miss this cycle; sampled only in IDLE.
- `miss_address`  in  ADDR_WIDTH  byte address of the missing access.
- `memory_data`  in  DATA_WIDTH  word returned by memory.
- `memory_data_valid`  in  1  `memory_data` valid this cycle.
- `fsm_busy`  out  1  fill in progress; stall request.
- `memory_read`  out  1  read request to memory this cycle.
- `memory_address`  out  ADDR_WIDTH  byte address of the current request.
- `write_data_array`  out  1  write `fill_data` into the cache at `word_num`.
- `write_tag_array`  out  1  write the tag/valid bit for the block.
- `word_num`  out  3  word index within the block for the current write.
- `fill_data`  out  DATA_WIDTH  data to the cache `Data_In`; equals `memory_data`.

## Operation
- States: IDLE, FILL.
- IDLE:
  - `miss_detected`=1 latches `base = {miss_address[15:4], 4'b0}` and `start = miss_address[3:1]` (or 0, see Configuration).
  - Clears `req_cnt` and `rcv_cnt` (3-bit each, plus done flags).
  - Transitions to FILL.
- FILL, request side:
  - `memory_read`=1 while fewer than 8 requests have been issued, one request per cycle.
  - `memory_address = base + 2*((start + req_cnt) mod 8)`.
  - `req_cnt` increments each request cycle.
- FILL, receive side:
  - Each cycle with `memory_data_valid`=1 asserts `write_data_array`=1 combinationally, with `word_num = (start + rcv_cnt) mod 8`; `rcv_cnt` increments.
- Completion:
  - On the 8th valid word, `write_tag_array`=1 in the same cycle as its data write.
  - State returns to IDLE on the next edge.
- Ignored inputs:
  - `miss_detected` in FILL.
  - `memory_data_valid` in IDLE (no write).
- Offset arithmetic is 3-bit and wraps mod 8. Address arithmetic never carries out of the block: bits [15:4] stay equal to `base`.
- Memory returns words in request order with arbitrary latency ≥1 and gaps. The block never issues more than 8 requests per fill.

## Timing
- Reset values: `fsm_busy`=0, `memory_read`=0, `memory_address`=0, `write_data_array`=0, `write_tag_array`=0, `word_num`=0. State IDLE; `base`, `start` and counters are 0.
- `fsm_busy` is `(state==FILL)`. It rises the cycle after `miss_detected` is sampled and falls the cycle after the tag write.
- Requests occupy FILL cycles 1–8 back-to-back. `memory_read` drops after the 8th request even if data is still outstanding.
- Data write latency: zero cycles from `memory_data_valid` to `write_data_array`.
- Simultaneous request and receive in one cycle is legal; the two counters are independent.
- Minimum fill duration is 9 cycles with latency-1 memory. With latency-4 memory (the current memory model), the tag write falls in FILL cycle 12.
- `rst` asserted mid-fill clears all state immediately. Outputs go to reset values asynchronously, and no tag write occurs. A stale `memory_data_valid` after reset is ignored.
- A new miss may be accepted on the first IDLE cycle after completion. There is no dead cycle beyond the FILL→IDLE edge.

## Configuration
- `CACHE_FILL_CRITICAL_WORD_FIRST_EN` defined: `start = miss_address[3:1]`. The missed word is fetched and written first, and the order wraps to word 0 after word 7.
- Undefined: `start` is forced to 0; words are always fetched and written in order 0..7.
- The tag write always coincides with the 8th received word in both builds.

## Test plan
- **Basic fill**, latency-4 memory, miss at 0x1810, macro undefined:
  - Requests go to 0x1810, 0x1812, …, 0x181E on cycles 1–8.
  - Writes occur with `word_num` 0..7 on cycles 5–12.
  - `write_tag_array`=1 only on cycle 12; `fsm_busy` is low from cycle 13.
- **Critical word first**, macro defined, miss at 0x190A:
  - Request address sequence 0x190A, 0x190C, 0x190E, 0x1900, …, 0x1908.
  - `word_num` sequence 5, 6, 7, 0, 1, 2, 3, 4.
  - Tag write on the word with index 4.
- **Gapped returns**: `memory_data_valid` toggles 1,0,1,0…
  - Exactly 8 writes with the correct indices; `fill_data` matches `memory_data` on each.
  - `fsm_busy` is held until the 8th write.
- **Miss during fill**: pulse `miss_detected` with 0x2000 mid-fill.
  - `base` is unchanged; no extra requests are issued.
  - A second miss presented on the first IDLE cycle starts a new fill to 0x2000.
- **Reset mid-fill**: assert `rst` after 3 writes.
  - All outputs go to 0 immediately and no tag write occurs.
  - A late `memory_data_valid` after reset produces no `write_data_array`.
- **Idle noise**: `memory_data_valid`=1 with no miss pending.
  - `write_data_array`, `write_tag_array` and `memory_read` stay 0.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss fill controller: fetches an 8-word block and streams it into the cache arrays
// Optional critical-word-first ordering is enabled by CACHE_FILL_CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic [DATA_WIDTH-1:0] memory_data,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  memory_read,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic                  write_tag_array,
  output logic [2:0]            word_num,
  output logic [DATA_WIDTH-1:0] fill_data
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-5:0] base;
  logic [2:0]            start;
  logic [2:0]            start_in;
  logic [2:0]            req_cnt;
  logic                  req_done;
  logic [2:0]            rcv_cnt;
  logic [2:0]            req_off;
  logic [2:0]            rcv_off;
  logic                  unused_addr_bits;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign start_in = miss_address[3:1];
`else
  assign start_in = 3'd0;
`endif

  assign unused_addr_bits = ^miss_address[3:0];

  // 3-bit sums wrap inside the block, so the upper address bits never change.
  assign req_off   = start + req_cnt;
  assign rcv_off   = start + rcv_cnt;
  assign fill_data = memory_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      start    <= 3'd0;
      req_cnt  <= 3'd0;
      req_done <= 1'b0;
      rcv_cnt  <= 3'd0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (miss_detected) begin
          base  <= miss_address[ADDR_WIDTH-1:4];
          start <= start_in;
        end
        req_cnt  <= 3'd0;
        req_done <= 1'b0;
        rcv_cnt  <= 3'd0;
      end else begin
        if (memory_read) begin
          req_cnt <= req_cnt + 3'd1;
          if (req_cnt == 3'd7) req_done <= 1'b1;
        end
        if (write_data_array) rcv_cnt <= rcv_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    state_next       = state;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    word_num         = 3'd0;
    case (state)
      IDLE: begin
        if (miss_detected) state_next = FILL;
      end
      FILL: begin
        fsm_busy    = 1'b1;
        memory_read = !req_done;
        if (memory_read) memory_address = {base, req_off, 1'b0};
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_num         = rcv_off;
          // The eighth word also commits the tag and ends the fill.
          if (rcv_cnt == 3'd7) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm against a block-fill reference model
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  word_num;
  logic [15:0] fill_data;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  cache_fill_fsm #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy), .memory_read(memory_read), .memory_address(memory_address),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array),
    .word_num(word_num), .fill_data(fill_data)
  );

  always #5 clk = ~clk;

  // One full fill: the model knows the request order, the in-order return queue,
  // and that requests occupy fill cycles 1..8 exactly.
  task automatic run_fill(input logic [15:0] addr, input int lat, input int gap_mode,
                          input bit noise, output int last_cyc);
    logic [15:0] b;
    int          s;
    int          pend[$];
    int          cyc, nreq, nrcv;
    bit          done, v;
    logic [15:0] exp_addr;
    logic [2:0]  exp_wn;
    b = {addr[15:4], 4'h0};
    s = CWF ? int'(addr[3:1]) : 0;
    miss_detected = 1'b1; miss_address = addr; memory_data_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fsm_busy !== 1'b0) begin n_fail++; $display("FAIL idle_before_miss busy got %0b want 0", fsm_busy); end
    @(posedge clk); #1;
    miss_detected = 1'b0; miss_address = 16'($urandom);
    cyc = 1; nreq = 0; nrcv = 0; done = 1'b0;
    while (!done && cyc <= 200) begin
      v = (pend.size() > 0) && (cyc >= pend[0] + lat);
      if (gap_mode == 1) v = v && (cyc % 2 == 1);
      else if (gap_mode == 2) v = v && ($urandom_range(0, 1) == 1);
      memory_data_valid = v;
      memory_data = 16'($urandom);
      miss_detected = noise && (cyc == 3 || cyc == 10);
      miss_address = 16'h2000;
      @(negedge clk);
      n_cmp++;
      if (fsm_busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_fill cyc %0d got %0b want 1", cyc, fsm_busy); end
      n_cmp++;
      if (memory_read !== 1'(cyc <= 8)) begin
        n_fail++; $display("FAIL memory_read cyc %0d got %0b want %0b", cyc, memory_read, cyc <= 8);
      end
      if (cyc <= 8) begin
        exp_addr = b + 16'(2 * ((s + nreq) % 8));
        n_cmp++;
        if (memory_address !== exp_addr) begin
          n_fail++; $display("FAIL memory_address cyc %0d got %h want %h", cyc, memory_address, exp_addr);
        end
        pend.push_back(cyc);
        nreq++;
      end
      n_cmp++;
      if (write_data_array !== v) begin
        n_fail++; $display("FAIL write_data_array cyc %0d got %0b want %0b", cyc, write_data_array, v);
      end
      if (v) begin
        exp_wn = 3'((s + nrcv) % 8);
        n_cmp++;
        if (word_num !== exp_wn) begin n_fail++; $display("FAIL word_num cyc %0d got %0d want %0d", cyc, word_num, exp_wn); end
        n_cmp++;
        if (fill_data !== memory_data) begin n_fail++; $display("FAIL fill_data cyc %0d got %h want %h", cyc, fill_data, memory_data); end
        n_cmp++;
        if (write_tag_array !== 1'(nrcv == 7)) begin
          n_fail++; $display("FAIL write_tag cyc %0d got %0b want %0b", cyc, write_tag_array, nrcv == 7);
        end
        void'(pend.pop_front());
        nrcv++;
        done = (nrcv == 8);
      end else begin
        n_cmp++;
        if (write_tag_array !== 1'b0) begin n_fail++; $display("FAIL write_tag_idle_cycle cyc %0d got %0b want 0", cyc, write_tag_array); end
      end
      if (!done) begin @(posedge clk); #1; cyc++; end
    end
    if (!done) begin n_cmp++; n_fail++; $display("FAIL fill_timeout got %0d writes want 8", nrcv); end
    last_cyc = cyc;
    @(posedge clk); #1;
    memory_data_valid = 1'b0; miss_detected = 1'b0;
    n_cmp++;
    if (fsm_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_fill got %0b want 0", fsm_busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0; memory_data = 16'h0; memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({fsm_busy, memory_read, write_data_array, write_tag_array} !== 4'b0 || memory_address !== 16'h0 || word_num !== 3'd0) begin
      n_fail++; $display("FAIL reset_outputs got %0b%0b%0b%0b addr %h wn %0d want all 0",
        fsm_busy, memory_read, write_data_array, write_tag_array, memory_address, word_num);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_fill();
    int lc;
    run_fill(16'h1810, 4, 0, 1'b0, lc);
    n_cmp++;
    if (lc !== 12) begin n_fail++; $display("FAIL basic_tag_cycle got %0d want 12", lc); end
  endtask

  task automatic test_critical_word();
    int lc;
    run_fill(16'h190A, 4, 0, 1'b0, lc);
    n_cmp++;
    if (lc !== 12) begin n_fail++; $display("FAIL cwf_tag_cycle got %0d want 12", lc); end
  endtask

  task automatic test_gapped();
    int lc;
    run_fill(16'($urandom), 2, 1, 1'b0, lc);
  endtask

  task automatic test_random_fills();
    int lc;
    for (int i = 0; i < 6; i++) run_fill(16'($urandom), int'($urandom_range(1, 5)), 2, 1'b0, lc);
  endtask

  task automatic test_back_to_back();
    int lc;
    run_fill(16'h1234, 3, 0, 1'b1, lc);
    run_fill(16'h2000, 1, 0, 1'b0, lc);
    n_cmp++;
    if (lc !== 9) begin n_fail++; $display("FAIL min_fill_cycles got %0d want 9", lc); end
  endtask

  task automatic test_reset_mid_fill();
    miss_detected = 1'b1; miss_address = 16'($urandom); memory_data_valid = 1'b0;
    @(posedge clk); #1;
    miss_detected = 1'b0;
    @(posedge clk); #1;
    memory_data_valid = 1'b1;
    repeat (3) begin memory_data = 16'($urandom); @(posedge clk); #1; end
    n_cmp++;
    if (fsm_busy !== 1'b1) begin n_fail++; $display("FAIL busy_before_reset got %0b want 1", fsm_busy); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({fsm_busy, memory_read, write_data_array, write_tag_array} !== 4'b0 || memory_address !== 16'h0 || word_num !== 3'd0) begin
      n_fail++; $display("FAIL async_reset_outputs got %0b%0b%0b%0b addr %h wn %0d want all 0",
        fsm_busy, memory_read, write_data_array, write_tag_array, memory_address, word_num);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({fsm_busy, memory_read, write_data_array, write_tag_array} !== 4'b0) begin
      n_fail++; $display("FAIL stale_valid_after_reset got %0b%0b%0b%0b want 0000",
        fsm_busy, memory_read, write_data_array, write_tag_array);
    end
    @(posedge clk); #1;
    memory_data_valid = 1'b0;
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 5; i++) begin
      memory_data_valid = 1'b1; memory_data = 16'($urandom); miss_detected = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({write_data_array, write_tag_array, memory_read, fsm_busy} !== 4'b0) begin
        n_fail++; $display("FAIL idle_noise got wr %0b tag %0b rd %0b busy %0b want 0",
          write_data_array, write_tag_array, memory_read, fsm_busy);
      end
      @(posedge clk); #1;
    end
    memory_data_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_critical_word();
    test_gapped();
    test_random_fills();
    test_back_to_back();
    test_reset_mid_fill();
    test_idle_noise();
    test_basic_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
